// File: rtl/mcp4725_i2c_target.sv
// MCP4725 12-bit DAC emulator on I2C: decodes fast-write, write-DAC and write-DAC+EEPROM
// commands, answers 5-byte status reads and models the EEPROM write-busy window.
module mcp4725_i2c_target #(
   parameter logic [5:0]  ADDR_HI         = 6'b110001,
   parameter logic [11:0] EE_INIT_CODE    = 12'h800,
   parameter logic [1:0]  EE_INIT_PD      = 2'b00,
   parameter logic [19:0] EE_WRITE_CYCLES = 20'd50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SCL_i,
   input  logic        SDA_i,
   output logic        SDA_o,
   output logic        SDA_t,
   input  logic        A0,
   output logic [11:0] dac_code,
   output logic [1:0]  pd_mode,
   output logic [11:0] ee_code,
   output logic [1:0]  ee_pd,
   output logic        dac_update,
   output logic        ee_busy
);
   typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} state_t;

   state_t      state, state_nxt;
   logic [2:0]  scl_q, sda_q;
   logic        scl, sda, start, stop, rise, fall;
   logic [3:0]  bit_cnt;
   logic [7:0]  sr, hi, rd_byte;
   logic [6:0]  tx;
   logic [2:0]  rd_idx, rd_sel, cmd_c;
   logic [1:0]  wr_idx, cmd_pd;
   logic        fast, nack;
   logic [19:0] ee_cnt;
   logic        sda_t_nxt, load_rd, wr_ack;

   assign SDA_o = 1'b0;

   // Two synchronizer flops plus one history flop per bus line
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], SCL_i};
         sda_q <= {sda_q[1:0], SDA_i};
      end
   end

   assign scl   = scl_q[1];
   assign sda   = sda_q[1];
   assign start = scl & scl_q[2] & sda_q[2] & ~sda;
   assign stop  = scl & scl_q[2] & ~sda_q[2] & sda;
   assign rise  = scl & ~scl_q[2];
   assign fall  = ~scl & scl_q[2];

   assign rd_sel = (state == ADDR_ACK) ? 3'd0 : rd_idx;

   always_comb begin
      case (rd_sel)
         3'd0:    rd_byte = {~ee_busy, 4'b1000, pd_mode, 1'b0};
         3'd1:    rd_byte = dac_code[11:4];
         3'd2:    rd_byte = {dac_code[3:0], 4'b0000};
         3'd3:    rd_byte = {1'b0, ee_pd, 1'b0, ee_code[11:8]};
         3'd4:    rd_byte = ee_code[7:0];
         default: rd_byte = 8'hFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Bus conditions override bit processing in the same clk
   always_comb begin
      state_nxt = state;
      if (start)
         state_nxt = ADDR;
      else if (stop)
         state_nxt = IDLE;
      else begin
         case (state)
            ADDR:     if (rise && bit_cnt == 4'd7)
                         state_nxt = (sr[6:0] == {ADDR_HI, A0}) ? ADDR_ACK : IGNORE;
            ADDR_ACK: if (fall && bit_cnt == 4'd9) state_nxt = sr[0] ? RD_BYTE : WR_BYTE;
            WR_BYTE:  if (rise && bit_cnt == 4'd7) state_nxt = WR_ACK;
            WR_ACK:   if (fall && bit_cnt == 4'd9) state_nxt = WR_BYTE;
            RD_BYTE:  if (rise && bit_cnt == 4'd7) state_nxt = RD_ACK;
            RD_ACK:   if (fall && bit_cnt == 4'd9) state_nxt = nack ? IGNORE : RD_BYTE;
            default:  state_nxt = state;
         endcase
      end
   end

   // SDA drive and byte strobes; SDA only moves on SCL fall except at START/STOP
   always_comb begin
      sda_t_nxt = SDA_t;
      load_rd   = 1'b0;
      wr_ack    = 1'b0;
      if (start || stop)
         sda_t_nxt = 1'b1;
      else if (fall) begin
         case (state)
            ADDR_ACK: begin
               if (bit_cnt == 4'd8)
                  sda_t_nxt = 1'b0;
               else if (bit_cnt == 4'd9 && sr[0]) begin
                  load_rd   = 1'b1;
                  sda_t_nxt = rd_byte[7];
               end else
                  sda_t_nxt = 1'b1;
            end
            WR_ACK: begin
               if (bit_cnt == 4'd8) begin
                  sda_t_nxt = 1'b0;
                  wr_ack    = 1'b1;
               end else
                  sda_t_nxt = 1'b1;
            end
            RD_BYTE: sda_t_nxt = tx[6];
            RD_ACK: begin
               if (bit_cnt == 4'd9 && !nack) begin
                  load_rd   = 1'b1;
                  sda_t_nxt = rd_byte[7];
               end else
                  sda_t_nxt = 1'b1;
            end
            default: sda_t_nxt = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         SDA_t      <= 1'b1;
         bit_cnt    <= 4'd0;
         sr         <= 8'd0;
         tx         <= 7'h7F;
         hi         <= 8'd0;
         rd_idx     <= 3'd0;
         wr_idx     <= 2'd0;
         cmd_c      <= 3'd0;
         cmd_pd     <= 2'd0;
         fast       <= 1'b0;
         nack       <= 1'b1;
         dac_code   <= EE_INIT_CODE;
         pd_mode    <= EE_INIT_PD;
         ee_code    <= EE_INIT_CODE;
         ee_pd      <= EE_INIT_PD;
         dac_update <= 1'b0;
         ee_busy    <= 1'b0;
         ee_cnt     <= 20'd0;
      end else begin
         SDA_t      <= sda_t_nxt;
         dac_update <= 1'b0;
         if (ee_cnt != 20'd0) begin
            ee_cnt <= ee_cnt - 20'd1;
            if (ee_cnt == 20'd1) ee_busy <= 1'b0;
         end
         if (start) begin
            bit_cnt <= 4'd0;
            wr_idx  <= 2'd0;
         end else if (!stop) begin
            if (rise && state inside {ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK})
               bit_cnt <= bit_cnt + 4'd1;
            if (fall && bit_cnt == 4'd9) bit_cnt <= 4'd0;
            if (rise && (state == ADDR || state == WR_BYTE)) sr <= {sr[6:0], sda};
            if (rise && state == RD_ACK) nack <= sda;
            if (fall && state == RD_BYTE) tx <= {tx[5:0], 1'b1};
            if (load_rd) begin
               tx     <= rd_byte[6:0];
               rd_idx <= (state == ADDR_ACK) ? 3'd1 : ((rd_idx == 3'd5) ? 3'd5 : rd_idx + 3'd1);
            end
            // Command decode: the first data byte fixes fast vs. normal mode
            if (wr_ack) begin
               if (wr_idx == 2'd0) begin
                  cmd_c  <= sr[7:5];
                  cmd_pd <= sr[2:1];
                  hi     <= sr;
                  fast   <= (sr[7:6] == 2'b00);
                  wr_idx <= 2'd1;
               end else if (fast) begin
                  if (wr_idx[0]) begin
                     dac_code   <= {hi[3:0], sr};
                     pd_mode    <= hi[5:4];
                     dac_update <= 1'b1;
                     wr_idx     <= 2'd2;
                  end else begin
                     hi     <= sr;
                     wr_idx <= 2'd3;
                  end
               end else begin
                  if (wr_idx == 2'd1) hi <= sr;
                  if (wr_idx == 2'd2 && cmd_c[2:1] == 2'b01) begin
                     dac_code   <= {hi, sr[7:4]};
                     pd_mode    <= cmd_pd;
                     dac_update <= 1'b1;
                     if (cmd_c[0] && !ee_busy) begin
                        ee_code <= {hi, sr[7:4]};
                        ee_pd   <= cmd_pd;
                        ee_busy <= 1'b1;
                        ee_cnt  <= EE_WRITE_CYCLES;
                     end
                  end
                  if (wr_idx != 2'd3) wr_idx <= wr_idx + 2'd1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_mcp4725_i2c_target.sv
// Directed bench for the MCP4725 I2C target: an I2C master model drives the bus and
// each scenario task checks ACKs, read data and register state against hand-derived values.
`timescale 1ns/1ps
module tb_mcp4725_i2c_target;
   localparam logic [19:0] EE_CYC = 20'd20000;

   logic        clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1, a0 = 1'b1;
   logic        sda_o, sda_t, sda_line, dac_update, ee_busy;
   logic [11:0] dac_code, ee_code;
   logic [1:0]  pd_mode, ee_pd;
   logic        low_seen = 1'b0;
   int          checks = 0, errors = 0, tq = 31;
   int          upd_cycles = 0, busy_cycles = 0, busy_base = 0;

   assign sda_line = sda_m & (sda_t ? 1'b1 : sda_o);

   mcp4725_i2c_target #(.EE_WRITE_CYCLES(EE_CYC)) dut (
      .clk(clk), .rst(rst), .SCL_i(scl_m), .SDA_i(sda_line), .SDA_o(sda_o), .SDA_t(sda_t),
      .A0(a0), .dac_code(dac_code), .pd_mode(pd_mode), .ee_code(ee_code), .ee_pd(ee_pd),
      .dac_update(dac_update), .ee_busy(ee_busy));

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (dac_update) upd_cycles++;
      if (ee_busy) busy_cycles++;
   end

   task automatic wait_q();
      repeat (tq) begin
         @(negedge clk);
         if (!sda_t) low_seen = 1'b1;
      end
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_q(); scl_m = 1'b1; wait_q(); sda_m = 1'b0; wait_q(); scl_m = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_q(); scl_m = 1'b1; wait_q(); sda_m = 1'b1; wait_q();
   endtask

   task automatic send_bit(input logic b);
      sda_m = b; wait_q(); scl_m = 1'b1; wait_q(); wait_q(); scl_m = 1'b0; wait_q();
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic get_ack(output logic ack);
      sda_m = 1'b1; wait_q(); scl_m = 1'b1; wait_q(); ack = ~sda_line; wait_q(); scl_m = 1'b0; wait_q();
   endtask

   task automatic read_byte(input logic m_ack, output logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sda_m = 1'b1; wait_q(); scl_m = 1'b1; wait_q(); b[i] = sda_line; wait_q(); scl_m = 1'b0; wait_q();
      end
      sda_m = ~m_ack; wait_q(); scl_m = 1'b1; wait_q(); wait_q(); scl_m = 1'b0; wait_q();
      sda_m = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (dac_code !== 12'h800) begin errors++; $display("FAIL reset_dac_code: got %h expected 800", dac_code); end
      checks++; if (pd_mode !== 2'b00) begin errors++; $display("FAIL reset_pd_mode: got %b expected 00", pd_mode); end
      checks++; if (ee_code !== 12'h800) begin errors++; $display("FAIL reset_ee_code: got %h expected 800", ee_code); end
      checks++; if (ee_pd !== 2'b00) begin errors++; $display("FAIL reset_ee_pd: got %b expected 00", ee_pd); end
      checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL reset_sda_t: got %b expected 1", sda_t); end
      checks++; if (ee_busy !== 1'b0) begin errors++; $display("FAIL reset_ee_busy: got %b expected 0", ee_busy); end
      checks++; if (dac_update !== 1'b0) begin errors++; $display("FAIL reset_dac_update: got %b expected 0", dac_update); end
      checks++; if (sda_o !== 1'b0) begin errors++; $display("FAIL reset_sda_o: got %b expected 0", sda_o); end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_fast_write();
      logic a;
      int   u0;
      tq = 31;
      u0 = upd_cycles;
      i2c_start();
      send_byte(8'hC6); get_ack(a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL fw_addr_ack: got %b expected 1", a); end
      send_byte(8'h1A); get_ack(a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL fw_byte1_ack: got %b expected 1", a); end
      send_byte(8'hBC); get_ack(a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL fw_byte2_ack: got %b expected 1", a); end
      checks++; if (dac_code !== 12'hABC) begin errors++; $display("FAIL fw_dac_code: got %h expected abc", dac_code); end
      checks++; if (pd_mode !== 2'b01) begin errors++; $display("FAIL fw_pd_mode: got %b expected 01", pd_mode); end
      checks++; if (upd_cycles - u0 !== 1) begin errors++; $display("FAIL fw_update_width: got %0d expected 1", upd_cycles - u0); end
      i2c_stop();
   endtask

   task automatic test_dac_eeprom();
      logic a;
      int   acks;
      tq = 125;
      acks = 0;
      busy_base = busy_cycles;
      i2c_start();
      send_byte(8'hC6); get_ack(a); if (a) acks++;
      send_byte(8'h66); get_ack(a); if (a) acks++;
      send_byte(8'h12); get_ack(a); if (a) acks++;
      send_byte(8'h30); get_ack(a); if (a) acks++;
      i2c_stop();
      checks++; if (acks !== 4) begin errors++; $display("FAIL ee_acks: got %0d expected 4", acks); end
      checks++; if (dac_code !== 12'h123) begin errors++; $display("FAIL ee_dac_code: got %h expected 123", dac_code); end
      checks++; if (pd_mode !== 2'b11) begin errors++; $display("FAIL ee_pd_mode: got %b expected 11", pd_mode); end
      checks++; if (ee_code !== 12'h123) begin errors++; $display("FAIL ee_ee_code: got %h expected 123", ee_code); end
      checks++; if (ee_pd !== 2'b11) begin errors++; $display("FAIL ee_ee_pd: got %b expected 11", ee_pd); end
      checks++; if (ee_busy !== 1'b1) begin errors++; $display("FAIL ee_busy_set: got %b expected 1", ee_busy); end
   endtask

   task automatic test_read();
      logic       a;
      logic [7:0] b;
      logic [7:0] exp_b [5];
      exp_b = '{8'h46, 8'h12, 8'h30, 8'h61, 8'h23};
      tq = 31;
      i2c_start();
      send_byte(8'hC7); get_ack(a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL rd_addr_ack: got %b expected 1", a); end
      for (int i = 0; i < 5; i++) begin
         read_byte(i < 4, b);
         checks++;
         if (b !== exp_b[i]) begin errors++; $display("FAIL rd_byte%0d: got %h expected %h", i, b, exp_b[i]); end
      end
      checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL rd_release_after_nack: got %b expected 1", sda_t); end
      i2c_stop();
   endtask

   task automatic test_busy_drop();
      logic a;
      int   acks, n;
      tq = 31;
      acks = 0;
      i2c_start();
      send_byte(8'hC6); get_ack(a); if (a) acks++;
      send_byte(8'h60); get_ack(a); if (a) acks++;
      send_byte(8'h45); get_ack(a); if (a) acks++;
      send_byte(8'h60); get_ack(a); if (a) acks++;
      i2c_stop();
      checks++; if (acks !== 4) begin errors++; $display("FAIL bd_acks: got %0d expected 4", acks); end
      checks++; if (dac_code !== 12'h456) begin errors++; $display("FAIL bd_dac_code: got %h expected 456", dac_code); end
      checks++; if (pd_mode !== 2'b00) begin errors++; $display("FAIL bd_pd_mode: got %b expected 00", pd_mode); end
      checks++; if (ee_code !== 12'h123) begin errors++; $display("FAIL bd_ee_code_kept: got %h expected 123", ee_code); end
      checks++; if (ee_pd !== 2'b11) begin errors++; $display("FAIL bd_ee_pd_kept: got %b expected 11", ee_pd); end
      n = 0;
      while (ee_busy && n < 3 * int'(EE_CYC)) begin
         @(negedge clk);
         n++;
      end
      checks++; if (ee_busy !== 1'b0) begin errors++; $display("FAIL bd_busy_timeout: got %b expected 0", ee_busy); end
      checks++;
      if (busy_cycles - busy_base !== int'(EE_CYC)) begin
         errors++; $display("FAIL bd_busy_length: got %0d expected %0d", busy_cycles - busy_base, EE_CYC);
      end
   endtask

   task automatic test_wrong_addr();
      logic a;
      int   acks, u0;
      tq = 31;
      acks = 0;
      u0 = upd_cycles;
      low_seen = 1'b0;
      i2c_start();
      send_byte(8'hC4); get_ack(a);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL wa_addr_ack: got %b expected 0", a); end
      send_byte(8'h00); get_ack(a); if (a) acks++;
      send_byte(8'h00); get_ack(a); if (a) acks++;
      i2c_stop();
      checks++; if (acks !== 0) begin errors++; $display("FAIL wa_data_acks: got %0d expected 0", acks); end
      checks++; if (low_seen !== 1'b0) begin errors++; $display("FAIL wa_sda_driven: got %b expected 0", low_seen); end
      checks++; if (dac_code !== 12'h456) begin errors++; $display("FAIL wa_dac_code: got %h expected 456", dac_code); end
      checks++; if (upd_cycles - u0 !== 0) begin errors++; $display("FAIL wa_update: got %0d expected 0", upd_cycles - u0); end
   endtask

   task automatic test_abort_restart();
      logic a;
      int   acks, u0;
      tq = 31;
      acks = 0;
      u0 = upd_cycles;
      i2c_start();
      send_byte(8'hC6); get_ack(a); if (a) acks++;
      send_byte(8'h05); get_ack(a); if (a) acks++;
      i2c_stop();
      checks++; if (dac_code !== 12'h456) begin errors++; $display("FAIL ab_dac_after_stop: got %h expected 456", dac_code); end
      checks++; if (upd_cycles - u0 !== 0) begin errors++; $display("FAIL ab_update_after_stop: got %0d expected 0", upd_cycles - u0); end
      i2c_start();
      send_byte(8'hC6); get_ack(a); if (a) acks++;
      send_byte(8'h0F); get_ack(a); if (a) acks++;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      i2c_start();
      send_byte(8'hC6); get_ack(a); if (a) acks++;
      send_byte(8'h02); get_ack(a); if (a) acks++;
      send_byte(8'h34); get_ack(a); if (a) acks++;
      i2c_stop();
      checks++; if (acks !== 7) begin errors++; $display("FAIL ab_acks: got %0d expected 7", acks); end
      checks++; if (dac_code !== 12'h234) begin errors++; $display("FAIL ab_dac_code: got %h expected 234", dac_code); end
      checks++; if (pd_mode !== 2'b00) begin errors++; $display("FAIL ab_pd_mode: got %b expected 00", pd_mode); end
      checks++; if (upd_cycles - u0 !== 1) begin errors++; $display("FAIL ab_update_count: got %0d expected 1", upd_cycles - u0); end
   endtask

   task automatic test_reset_mid_read();
      tq = 31;
      i2c_start();
      send_byte(8'hC7);
      sda_m = 1'b1;
      wait_q();
      @(negedge clk);
      checks++; if (sda_t !== 1'b0) begin errors++; $display("FAIL rmr_ack_driven: got %b expected 0", sda_t); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL rmr_sda_released: got %b expected 1", sda_t); end
      checks++; if (dac_code !== 12'h800) begin errors++; $display("FAIL rmr_dac_code: got %h expected 800", dac_code); end
      @(negedge clk);
      rst = 1'b0;
      i2c_stop();
   endtask

   initial begin
      test_reset();
      test_fast_write();
      test_dac_eeprom();
      test_read();
      test_busy_drop();
      test_wrong_addr();
      test_abort_restart();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
